// File: rtl/iic_slave_regs.sv
// I2C target with a 16x8 register file.
// The first byte after the address loads the register pointer. Following
// bytes are written to the register file with a pointer auto-increment.
// Reads return bytes from the current pointer. The pointer wraps 15 -> 0.
// Bus pins are oversampled on GCLK. SCL is never stretched.
module iic_slave_regs #(
    parameter logic [6:0] C_SLAVE_ADDR = 7'h50
) (
    input  logic       GCLK,
    input  logic       RESET,
    input  logic       Scl_I,
    input  logic       Sda_I,
    output logic       Sda_O,
    output logic       Sda_T,
    output logic       wr_valid,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP
    } state_t;

    logic       scl_sync1_reg, scl_sync2_reg, scl_hist_reg;
    logic       sda_sync1_reg, sda_sync2_reg, sda_hist_reg;
    state_t     state_reg;
    logic [2:0] cnt_reg;
    logic [7:0] shift_reg;
    logic       phase_reg;
    logic       rw_reg;
    logic       ack_reg;
    logic [3:0] ptr_reg;
    logic       sda_t_reg;
    logic       busy_reg;
    logic       wr_valid_reg;
    logic [3:0] wr_addr_reg;
    logic [7:0] wr_data_reg;
    logic [7:0] rd_data_reg;
    logic [7:0] regfile [16];

    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] byte_in;

    assign scl_rise  =  scl_sync2_reg & ~scl_hist_reg;
    assign scl_fall  = ~scl_sync2_reg &  scl_hist_reg;
    assign start_det =  scl_sync2_reg &  sda_hist_reg & ~sda_sync2_reg;
    assign stop_det  =  scl_sync2_reg & ~sda_hist_reg &  sda_sync2_reg;
    assign byte_in   = {shift_reg[6:0], sda_sync2_reg};

    assign Sda_O    = 1'b0;
    assign Sda_T    = sda_t_reg;
    assign wr_valid = wr_valid_reg;
    assign wr_addr  = wr_addr_reg;
    assign wr_data  = wr_data_reg;
    assign busy     = busy_reg;

    // Two-flop synchronizers plus one history flop for edge detection; idle bus is high.
    always_ff @(posedge GCLK) begin
        if (RESET) begin
            scl_sync1_reg <= 1'b1; scl_sync2_reg <= 1'b1; scl_hist_reg <= 1'b1;
            sda_sync1_reg <= 1'b1; sda_sync2_reg <= 1'b1; sda_hist_reg <= 1'b1;
        end else begin
            scl_sync1_reg <= Scl_I;  scl_sync2_reg <= scl_sync1_reg; scl_hist_reg <= scl_sync2_reg;
            sda_sync1_reg <= Sda_I;  sda_sync2_reg <= sda_sync1_reg; sda_hist_reg <= sda_sync2_reg;
        end
    end

    // Register file: committed one GCLK after the wr_valid pulse. The read port is registered.
    always_ff @(posedge GCLK) begin
        if (RESET) begin
            for (int i = 0; i < 16; i++) regfile[i] <= 8'h00;
            rd_data_reg <= 8'h00;
        end else begin
            if (wr_valid_reg) regfile[wr_addr_reg] <= wr_data_reg;
            rd_data_reg <= regfile[ptr_reg];
        end
    end

    // Protocol FSM. Each *_ACK state spans the 9th clock. The first SCL fall
    // sets up the ACK level, and the second SCL fall ends the ACK bit.
    always_ff @(posedge GCLK) begin
        if (RESET) begin
            state_reg    <= IDLE;
            cnt_reg      <= 3'd0;
            shift_reg    <= 8'h00;
            phase_reg    <= 1'b0;
            rw_reg       <= 1'b0;
            ack_reg      <= 1'b1;
            ptr_reg      <= 4'd0;
            sda_t_reg    <= 1'b1;
            busy_reg     <= 1'b0;
            wr_valid_reg <= 1'b0;
            wr_addr_reg  <= 4'd0;
            wr_data_reg  <= 8'h00;
        end else begin
            wr_valid_reg <= 1'b0;
            if (stop_det) begin
                state_reg <= IDLE;
                sda_t_reg <= 1'b1;
                busy_reg  <= 1'b0;
            end else if (start_det) begin
                state_reg <= ADDR;
                cnt_reg   <= 3'd0;
                phase_reg <= 1'b0;
                sda_t_reg <= 1'b1;
            end else begin
                case (state_reg)
                    ADDR: if (scl_rise) begin
                        shift_reg <= byte_in;
                        cnt_reg   <= cnt_reg + 3'd1;
                        if (cnt_reg == 3'd7) begin
                            if (byte_in[7:1] == C_SLAVE_ADDR && byte_in[7:1] != 7'h00) begin
                                state_reg <= ADDR_ACK;
                                rw_reg    <= byte_in[0];
                                busy_reg  <= 1'b1;
                                phase_reg <= 1'b0;
                            end else begin
                                state_reg <= IDLE;
                                busy_reg  <= 1'b0;
                            end
                        end
                    end
                    PTR, WRITE: if (scl_rise) begin
                        shift_reg <= byte_in;
                        cnt_reg   <= cnt_reg + 3'd1;
                        if (cnt_reg == 3'd7) begin
                            phase_reg <= 1'b0;
                            if (state_reg == PTR) begin
                                ptr_reg   <= byte_in[3:0];
                                state_reg <= PTR_ACK;
                            end else begin
                                wr_valid_reg <= 1'b1;
                                wr_addr_reg  <= ptr_reg;
                                wr_data_reg  <= byte_in;
                                ptr_reg      <= ptr_reg + 4'd1;
                                state_reg    <= WRITE_ACK;
                            end
                        end
                    end
                    ADDR_ACK, PTR_ACK, WRITE_ACK: if (scl_fall) begin
                        if (!phase_reg) begin
                            sda_t_reg <= 1'b0;
                            phase_reg <= 1'b1;
                        end else begin
                            phase_reg <= 1'b0;
                            cnt_reg   <= 3'd0;
                            if (state_reg == ADDR_ACK && rw_reg) begin
                                state_reg <= READ;
                                sda_t_reg <= rd_data_reg[7];
                                shift_reg <= {rd_data_reg[6:0], 1'b1};
                            end else begin
                                state_reg <= (state_reg == ADDR_ACK) ? PTR : WRITE;
                                sda_t_reg <= 1'b1;
                            end
                        end
                    end
                    READ: begin
                        if (scl_rise) begin
                            cnt_reg <= cnt_reg + 3'd1;
                            if (cnt_reg == 3'd7) begin
                                state_reg <= READ_ACK;
                                phase_reg <= 1'b0;
                            end
                        end else if (scl_fall) begin
                            sda_t_reg <= shift_reg[7];
                            shift_reg <= {shift_reg[6:0], 1'b1};
                        end
                    end
                    READ_ACK: begin
                        if (scl_rise && phase_reg) begin
                            ack_reg <= sda_sync2_reg;
                            ptr_reg <= ptr_reg + 4'd1;
                        end else if (scl_fall) begin
                            if (!phase_reg) begin
                                sda_t_reg <= 1'b1;
                                phase_reg <= 1'b1;
                            end else begin
                                phase_reg <= 1'b0;
                                cnt_reg   <= 3'd0;
                                if (!ack_reg) begin
                                    state_reg <= READ;
                                    sda_t_reg <= rd_data_reg[7];
                                    shift_reg <= {rd_data_reg[6:0], 1'b1};
                                end else begin
                                    state_reg <= WAIT_STOP;
                                    sda_t_reg <= 1'b1;
                                end
                            end
                        end
                    end
                    IDLE, WAIT_STOP: ;
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule
